// File: rtl/axis_circular_ram_reader.sv
// Reads cfg_length words from a circular BRAM buffer starting at cfg_start and
// emits them as one AXI-Stream packet; the read address wraps at 2^BRAM_ADDR_WIDTH.
module axis_circular_ram_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_start,
  input  logic [BRAM_ADDR_WIDTH:0]    cfg_length,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [1:0]                  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [BRAM_ADDR_WIDTH:0] FULL_LAP = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};
  localparam logic [BRAM_ADDR_WIDTH:0] REM_ONE  = {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [BRAM_ADDR_WIDTH:0] REM_ZERO = '0;

  logic [1:0]                 state;
  logic                       start_q;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic [BRAM_ADDR_WIDTH:0]   remaining;
  logic [BRAM_ADDR_WIDTH:0]   len_sat;
  logic [1:0]                 pipe_v;
  logic [1:0]                 pipe_l;
  logic [AXIS_TDATA_WIDTH:0]  fifo_mem [4];
  logic [1:0]                 wr_ptr;
  logic [1:0]                 rd_ptr;
  logic [2:0]                 fifo_count;
  logic [AXIS_TDATA_WIDTH:0]  fifo_head;
  logic                       start_edge;
  logic                       credit_ok;
  logic                       issue;
  logic                       push;
  logic                       pop;

  // Stream handshake: a beat transfers on a clock edge where m_axis_tvalid and
  // m_axis_tready are both high; once tvalid rises, tdata/tlast hold until that edge.

  assign start_edge = start & ~start_q;
  assign len_sat    = (cfg_length > FULL_LAP) ? FULL_LAP : cfg_length;

  // Words already in the FIFO plus reads still in the BRAM pipeline must fit the
  // 4-entry FIFO, so a read is only launched when a slot is guaranteed for it.
  assign credit_ok = ({1'b0, fifo_count} + {3'b000, pipe_v[0]} + {3'b000, pipe_v[1]}) < 4'd4;
  assign issue     = (state == READ) && credit_ok;
  assign push      = pipe_v[1];
  assign pop       = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= IDLE;
      start_q         <= start;
      addr            <= '0;
      remaining       <= '0;
      bram_porta_addr <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            addr      <= cfg_start;
            remaining <= len_sat;
            state     <= (len_sat == REM_ZERO) ? FIN : READ;
          end
        end
        READ: begin
          if (issue) begin
            bram_porta_addr <= addr;
            addr            <= addr + 1'b1;
            remaining       <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_axis_tlast) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pipe_v     <= '0;
      pipe_l     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      pipe_v <= {pipe_v[0], issue};
      pipe_l <= {pipe_l[0], issue && (remaining == REM_ONE)};
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_l[1], bram_porta_rddata};
  end

  assign fifo_head      = fifo_mem[rd_ptr];
  assign m_axis_tvalid  = (fifo_count != 3'd0);
  assign m_axis_tdata   = fifo_head[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast   = m_axis_tvalid && fifo_head[AXIS_TDATA_WIDTH];
  assign busy           = (state == READ) || (state == DRAIN);
  assign done           = (state == FIN);
  assign bram_porta_clk = aclk;
  assign bram_porta_rst = ~aresetn;
  assign fsm_state      = state;

endmodule

// File: doc/axis_circular_ram_reader.md
Name: axis_circular_ram_reader

Overview:
- Read-side companion to the circular capture path: after the RAM writer has filled a circular BRAM buffer, this block reads a window of cfg_length words back in chronological order, starting at cfg_start (the captured start position) and wrapping at 2^BRAM_ADDR_WIDTH.
- Drives a BRAM read port with fixed 2-cycle latency and emits the data as one AXI-Stream packet with tlast on the final word.
- A 4-entry output FIFO with credit-based read issue gives full back-pressure tolerance at one word per cycle.

Parameters:
- AXIS_TDATA_WIDTH, 32, stream and BRAM data width.
- BRAM_ADDR_WIDTH, 16, BRAM word-address width; buffer depth is 2^BRAM_ADDR_WIDTH words.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- cfg_start  in  BRAM_ADDR_WIDTH  first word address; sampled on start
- cfg_length  in  BRAM_ADDR_WIDTH+1  words to read; sampled on start
- start  in  1  level; a rising edge launches a read-out
- busy  out  1  high from the accepted start until the last beat handshakes
- done  out  1  one-cycle pulse at packet completion
- bram_porta_clk  out  1  equals aclk
- bram_porta_rst  out  1  equals ~aresetn
- bram_porta_addr  out  BRAM_ADDR_WIDTH  read address
- bram_porta_rddata  in  AXIS_TDATA_WIDTH  read data, valid 2 cycles after the address is issued
- m_axis_tready  in  1
- m_axis_tdata  out  AXIS_TDATA_WIDTH
- m_axis_tvalid  out  1
- m_axis_tlast  out  1

Behaviour:
- Reset (aresetn low at a clock edge):
  - busy=0, done=0, m_axis_tvalid=0, m_axis_tlast=0, bram_porta_addr=0.
  - FIFO emptied, in-flight pipeline cleared, FSM to IDLE, start edge detector primed with the current start level.
  - Reset mid-packet aborts the packet; no tlast or done is produced.
- FSM states:
  - IDLE: on a start rising edge, latch addr=cfg_start and remaining=cfg_length.
    - If cfg_length=0: go to FIN.
    - Otherwise: set busy=1 and go to READ.
  - READ: issue one read per cycle when credit allows. Each issue sets bram_porta_addr=addr, then addr increments modulo 2^BRAM_ADDR_WIDTH (natural wrap from all-ones to 0) and remaining decrements. When the last read is issued, go to DRAIN.
  - DRAIN: wait until the tlast beat handshakes (tvalid & tready), then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Credit rule: issue only when fifo_count + inflight < 4, where inflight counts issued reads not yet written into the FIFO (0..2). The FIFO never overflows and never drops or duplicates a word.
- Pipeline: a 2-stage valid/last shift register tracks the BRAM latency. Its output writes rddata into the FIFO, tagged last when the issued read had remaining=1.
- Latency: with tready held high, the first beat is valid 3 cycles after the start edge is sampled (edge, issue, +2 latency), then one beat per cycle with no bubbles.
- Output:
  - m_axis_tvalid = FIFO not empty.
  - tdata and tlast come from the FIFO head.
  - tdata/tlast stay stable while tvalid=1 and tready=0.
- start edges while busy, or in FIN, are ignored; the edge detector still tracks the level.
- cfg_start and cfg_length changes after a start is accepted have no effect on the current packet.
- cfg_length above 2^BRAM_ADDR_WIDTH is saturated to 2^BRAM_ADDR_WIDTH (one full lap, no re-read).
- A full-lap read starting at cfg_start=S ends at address S-1 mod 2^BRAM_ADDR_WIDTH.

Test Plan:
- BRAM model holds addr as data, BRAM_ADDR_WIDTH=4, cfg_start=3, cfg_length=5, tready=1 -> tdata 3,4,5,6,7 on consecutive cycles; tlast only on 7; done pulses once; busy falls with the last beat.
- cfg_start=14, cfg_length=4 -> tdata 14,15,0,1 (wrap); tlast on 1.
- cfg_length=0 -> no tvalid; done pulses 1–2 cycles after the start edge; busy never rises.
- cfg_start=0, cfg_length=16, random tready (~50%) -> all 16 words delivered in order with no drop or duplicate; bram_porta_addr never runs more than 4 words ahead of the last consumed word; tdata stable while stalled.
- Second start edge mid-packet, and cfg_start changed mid-packet -> ignored; the first packet completes unchanged.
- aresetn low for 1 cycle after the 3rd beat of a 10-word packet -> tvalid=0, busy=0 next cycle, no done; a fresh start afterwards delivers a complete correct packet.
- cfg_length=20 with BRAM_ADDR_WIDTH=4 -> exactly 16 beats delivered.
